// File: rtl/dcmac_rx_seg_to_axis.sv
// dcmac_rx_seg_to_axis
//   Merges the per-segment output of the RX deskew stage into 512-bit AXI-Stream beats and
//   buffers them in a packet-aware FIFO so the consumer may apply tready. When the FIFO
//   runs out of room, packets are truncated (tlast+tuser forced) or dropped whole, so
//   framing on the output is never broken.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   inN_tdata/tid/tuser/tlast/tvalid
//                                 segment N: data, MTY (empty upper bytes on tlast),
//                                 tuser = {ENA, SOP, ERR}, end-of-packet, beat valid
//   axis_out_*                    merged AXI-Stream output with byte-accurate tkeep
//   pkt_count                     packets whose tlast beat entered the FIFO
//   drop_count                    packets dropped or truncated
//   overflow                      one-cycle pulse per drop/truncate event
module dcmac_rx_seg_to_axis #(
    parameter int SEG_COUNT  = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,

    input  logic [127:0] in0_tdata,
    input  logic [3:0]   in0_tid,
    input  logic [2:0]   in0_tuser,
    input  logic         in0_tlast,
    input  logic         in0_tvalid,
    input  logic [127:0] in1_tdata,
    input  logic [3:0]   in1_tid,
    input  logic [2:0]   in1_tuser,
    input  logic         in1_tlast,
    input  logic         in1_tvalid,
    input  logic [127:0] in2_tdata,
    input  logic [3:0]   in2_tid,
    input  logic [2:0]   in2_tuser,
    input  logic         in2_tlast,
    input  logic         in2_tvalid,
    input  logic [127:0] in3_tdata,
    input  logic [3:0]   in3_tid,
    input  logic [2:0]   in3_tuser,
    input  logic         in3_tlast,
    input  logic         in3_tvalid,

    output logic [511:0] axis_out_tdata,
    output logic [63:0]  axis_out_tkeep,
    output logic         axis_out_tuser,
    output logic         axis_out_tlast,
    output logic         axis_out_tvalid,
    input  logic         axis_out_tready,

    output logic [31:0]  pkt_count,
    output logic [31:0]  drop_count,
    output logic         overflow
);

    localparam int PtrW  = $clog2(FIFO_DEPTH);
    localparam int CntW  = PtrW + 1;
    localparam int WordW = 512 + 64 + 2;

    localparam logic [CntW-1:0] OccSafe = CntW'(FIFO_DEPTH - 2);
    localparam logic [CntW-1:0] OccLast = CntW'(FIFO_DEPTH - 1);

    // ---------------------------------------------------------------------------------
    // Segment gather
    // ---------------------------------------------------------------------------------
    logic [127:0] seg_data  [4];
    logic [3:0]   seg_tid   [4];
    logic [2:0]   seg_user  [4];
    logic [3:0]   seg_last;
    logic [3:0]   seg_valid;

    assign seg_data[0] = in0_tdata;
    assign seg_data[1] = in1_tdata;
    assign seg_data[2] = in2_tdata;
    assign seg_data[3] = in3_tdata;
    assign seg_tid[0]  = in0_tid;
    assign seg_tid[1]  = in1_tid;
    assign seg_tid[2]  = in2_tid;
    assign seg_tid[3]  = in3_tid;
    assign seg_user[0] = in0_tuser;
    assign seg_user[1] = in1_tuser;
    assign seg_user[2] = in2_tuser;
    assign seg_user[3] = in3_tuser;
    assign seg_last    = {in3_tlast, in2_tlast, in1_tlast, in0_tlast};
    assign seg_valid   = {in3_tvalid, in2_tvalid, in1_tvalid, in0_tvalid};

    // ---------------------------------------------------------------------------------
    // Stage 1: merge segments
    // ---------------------------------------------------------------------------------
    logic [511:0] c_data;
    logic [63:0]  c_keep;
    logic         c_last, c_err, c_sop, c_any;

    always_comb begin
        c_data = '0;
        c_keep = '0;
        c_last = 1'b0;
        c_err  = 1'b0;
        c_any  = 1'b0;
        // c_last doubles as "a lower segment already ended the packet"
        for (int n = 0; n < SEG_COUNT; n++) begin
            if (seg_valid[n] && seg_user[n][2] && !c_last) begin
                c_any                = 1'b1;
                c_data[128*n +: 128] = seg_data[n];
                if (seg_last[n]) begin
                    c_keep[16*n +: 16] = 16'hFFFF >> seg_tid[n];
                    c_last             = 1'b1;
                    c_err              = seg_user[n][0];
                end else begin
                    c_keep[16*n +: 16] = 16'hFFFF;
                end
            end
        end
        c_sop = seg_valid[0] && seg_user[0][2] && seg_user[0][1];
    end

    logic         s1_valid_q;
    logic [511:0] s1_data_q;
    logic [63:0]  s1_keep_q;
    logic         s1_last_q, s1_err_q, s1_sop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_keep_q  <= '0;
            s1_last_q  <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_sop_q   <= 1'b0;
        end else begin
            s1_valid_q <= in0_tvalid && c_any;
            s1_data_q  <= c_data;
            s1_keep_q  <= c_keep;
            s1_last_q  <= c_last;
            s1_err_q   <= c_err;
            s1_sop_q   <= c_sop;
        end
    end

    // ---------------------------------------------------------------------------------
    // Write FSM: decides per beat whether it enters the FIFO
    // ---------------------------------------------------------------------------------
    typedef enum logic {StAccept, StDiscard} wr_state_e;

    wr_state_e       state_q, state_d;
    logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic            out_valid_q;
    logic [CntW-1:0] occ;
    logic            push, push_last, push_err, drop_evt;

    // Occupancy includes the beat held in the output register; a same-cycle pop is ignored.
    assign occ = fifo_cnt_q + {{(CntW-1){1'b0}}, out_valid_q};

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_last = s1_last_q;
        push_err  = s1_err_q && s1_last_q;
        drop_evt  = 1'b0;
        if (s1_valid_q) begin
            if (state_q == StDiscard && !s1_sop_q) begin
                // Tail of a packet already dropped or truncated
                if (s1_last_q) state_d = StAccept;
            end else if (occ <= OccSafe) begin
                push    = 1'b1;
                state_d = StAccept;
            end else if (occ == OccLast) begin
                // Last free slot: close the packet here with an error if it is not ending
                push = 1'b1;
                if (!s1_last_q) begin
                    push_last = 1'b1;
                    push_err  = 1'b1;
                    drop_evt  = 1'b1;
                    state_d   = StDiscard;
                end else begin
                    state_d = StAccept;
                end
            end else begin
                drop_evt = 1'b1;
                state_d  = s1_last_q ? StAccept : StDiscard;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StDiscard;
        else       state_q <= state_d;
    end

    // ---------------------------------------------------------------------------------
    // FIFO with registered first-word-fall-through output
    // ---------------------------------------------------------------------------------
    logic [WordW-1:0] mem [FIFO_DEPTH];
    logic [WordW-1:0] wr_word, out_word_q;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic             pop, load_out, take_mem, bypass, mem_wr;

    assign wr_word  = {push_err, push_last, s1_keep_q, s1_data_q};
    assign pop      = out_valid_q && axis_out_tready;
    assign load_out = !out_valid_q || pop;
    assign take_mem = load_out && (fifo_cnt_q != '0);
    // An empty memory lets the incoming beat go straight to the output register
    assign bypass   = load_out && (fifo_cnt_q == '0) && push;
    assign mem_wr   = push && !bypass;

    assign fifo_cnt_d = fifo_cnt_q + {{(CntW-1){1'b0}}, mem_wr}
                                   - {{(CntW-1){1'b0}}, take_mem};

    always_ff @(posedge clk) begin
        if (mem_wr) mem[wr_ptr_q] <= wr_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else begin
            if (mem_wr)   wr_ptr_q <= wr_ptr_q + 1'b1;
            if (take_mem) rd_ptr_q <= rd_ptr_q + 1'b1;
            fifo_cnt_q <= fifo_cnt_d;
            if (load_out) begin
                if (take_mem) begin
                    out_valid_q <= 1'b1;
                    out_word_q  <= mem[rd_ptr_q];
                end else if (bypass) begin
                    out_valid_q <= 1'b1;
                    out_word_q  <= wr_word;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign axis_out_tdata  = out_word_q[511:0];
    assign axis_out_tkeep  = out_word_q[575:512];
    assign axis_out_tlast  = out_word_q[576];
    assign axis_out_tuser  = out_word_q[577];
    assign axis_out_tvalid = out_valid_q;

    // ---------------------------------------------------------------------------------
    // Statistics
    // ---------------------------------------------------------------------------------
    logic [31:0] pkt_count_q, drop_count_q;
    logic        overflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (push && push_last) pkt_count_q <= pkt_count_q + 32'd1;
            if (drop_evt)          drop_count_q <= drop_count_q + 32'd1;
            overflow_q <= drop_evt;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_dcmac_rx_seg_to_axis.sv
// Bench for dcmac_rx_seg_to_axis. Packets are described by byte length; the expected
// output beats (byte-mask tkeep, data, tlast/tuser) are derived from that length.
module tb_dcmac_rx_seg_to_axis;

    localparam int SEG_COUNT = 2;
    localparam int DEPTH     = 16;

    typedef struct packed {
        logic         user;
        logic         last;
        logic [63:0]  keep;
        logic [511:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] b_data  [4];
    logic [3:0]   b_tid   [4];
    logic [2:0]   b_user  [4];
    logic         b_last  [4];
    logic         b_valid [4];
    logic [511:0] axis_out_tdata;
    logic [63:0]  axis_out_tkeep;
    logic         axis_out_tuser, axis_out_tlast, axis_out_tvalid, axis_out_tready;
    logic [31:0]  pkt_count, drop_count;
    logic         overflow;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    ovf_cnt = 0;
    bit    rand_rdy = 0;
    beat_t exp_q[$];
    beat_t got_q[$];
    int    got_cyc[$];

    dcmac_rx_seg_to_axis #(.SEG_COUNT(SEG_COUNT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in0_tdata(b_data[0]), .in0_tid(b_tid[0]), .in0_tuser(b_user[0]),
        .in0_tlast(b_last[0]), .in0_tvalid(b_valid[0]),
        .in1_tdata(b_data[1]), .in1_tid(b_tid[1]), .in1_tuser(b_user[1]),
        .in1_tlast(b_last[1]), .in1_tvalid(b_valid[1]),
        .in2_tdata(b_data[2]), .in2_tid(b_tid[2]), .in2_tuser(b_user[2]),
        .in2_tlast(b_last[2]), .in2_tvalid(b_valid[2]),
        .in3_tdata(b_data[3]), .in3_tid(b_tid[3]), .in3_tuser(b_user[3]),
        .in3_tlast(b_last[3]), .in3_tvalid(b_valid[3]),
        .axis_out_tdata(axis_out_tdata), .axis_out_tkeep(axis_out_tkeep),
        .axis_out_tuser(axis_out_tuser), .axis_out_tlast(axis_out_tlast),
        .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
        .pkt_count(pkt_count), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output capture, half a cycle away from the active edge
    always @(negedge clk) begin
        if (axis_out_tvalid && axis_out_tready) begin
            got_q.push_back({axis_out_tuser, axis_out_tlast, axis_out_tkeep, axis_out_tdata});
            got_cyc.push_back(cyc);
        end
        if (overflow) ovf_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) axis_out_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle_inputs();
        for (int s = 0; s < 4; s++) b_valid[s] = 1'b0;
    endtask

    task automatic do_reset(input bit rdy);
        reset = 1'b1;
        idle_inputs();
        axis_out_tready = rdy;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Drive beat b of a len-byte packet for one cycle and return the beat it should produce.
    task automatic drive_beat(input int len, input bit err, input int b, output beat_t e);
        int nb;
        nb = (len + 31) / 32;
        e  = '0;
        for (int s = 0; s < 4; s++) begin
            int           o;
            logic [127:0] d;
            o = b * 32 + s * 16;
            d = {$urandom, $urandom, $urandom, $urandom};
            b_data[s] = d;
            if (s < SEG_COUNT && o < len) begin
                b_valid[s] = 1'b1;
                b_last[s]  = (o + 16 >= len);
                b_tid[s]   = b_last[s] ? 4'(o + 16 - len) : 4'($urandom);
                b_user[s]  = {1'b1, (b == 0 && s == 0), b_last[s] ? err : 1'($urandom)};
                for (int i = 0; i < 16; i++) e.keep[s * 16 + i] = (o + i < len);
                e.data[s * 128 +: 128] = d;
            end else if (s < SEG_COUNT) begin
                // Beyond the packet end: ENA and tlast are noise that must be ignored
                b_valid[s] = 1'b1;
                b_last[s]  = 1'($urandom);
                b_tid[s]   = 4'($urandom);
                b_user[s]  = 3'($urandom);
            end else begin
                b_valid[s] = 1'($urandom);
                b_last[s]  = 1'($urandom);
                b_tid[s]   = 4'($urandom);
                b_user[s]  = 3'($urandom);
            end
        end
        e.last = (b == nb - 1);
        e.user = e.last && err;
    endtask

    // keep_beats < 0: whole packet expected; k >= 0: only first k beats, k-th closed as error.
    task automatic send_pkt(input int len, input bit err, input int keep_beats,
                            input bit open_after1);
        int    nb;
        beat_t e;
        nb = (len + 31) / 32;
        for (int b = 0; b < nb; b++) begin
            drive_beat(len, err, b, e);
            if (keep_beats < 0 || b < keep_beats) begin
                if (b == keep_beats - 1 && b != nb - 1) begin
                    e.last = 1'b1;
                    e.user = 1'b1;
                end
                exp_q.push_back(e);
            end
            tick();
            if (open_after1 && b == 0) axis_out_tready = 1'b1;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        beat_t e;
        int    g0;
        reset = 1'b1;
        idle_inputs();
        axis_out_tready = 1'b1;
        tick();
        checks++; if (axis_out_tvalid !== 1'b0) begin errors++;
            $display("FAIL reset_tvalid: got %b required 0", axis_out_tvalid); end
        reset = 1'b0;
        tick();
        checks++; if (axis_out_tdata !== '0) begin errors++;
            $display("FAIL reset_tdata: got %h required 0", axis_out_tdata); end
        checks++; if (axis_out_tkeep !== '0) begin errors++;
            $display("FAIL reset_tkeep: got %h required 0", axis_out_tkeep); end
        checks++; if ({axis_out_tlast, axis_out_tuser} !== 2'b00) begin errors++;
            $display("FAIL reset_tlast_tuser: got %b required 00", {axis_out_tlast, axis_out_tuser});
        end
        checks++; if (pkt_count !== 32'd0 || drop_count !== 32'd0) begin errors++;
            $display("FAIL reset_counts: got %0d/%0d required 0/0", pkt_count, drop_count); end
        checks++; if (overflow !== 1'b0) begin errors++;
            $display("FAIL reset_overflow: got %b required 0", overflow); end
        // Write side starts discarding: a mid-packet tail must not appear
        g0 = got_q.size();
        drive_beat(64, 0, 1, e);
        tick();
        idle_inputs();
        repeat (4) tick();
        checks++; if (got_q.size() != g0) begin errors++;
            $display("FAIL reset_discard: got %0d beats required 0", got_q.size() - g0); end
        checks++; if (pkt_count !== 32'd0) begin errors++;
            $display("FAIL reset_discard_cnt: got %0d required 0", pkt_count); end
    endtask

    task automatic test_basic();
        int g0, st;
        do_reset(1);
        exp_q.delete();
        g0 = got_q.size();
        st = cyc;
        send_pkt(48, 0, -1, 0);
        for (int k = 0; k < 50 && got_q.size() - g0 < exp_q.size(); k++) tick();
        repeat (4) tick();
        checks++; if (got_q.size() - g0 != exp_q.size()) begin errors++;
            $display("FAIL basic_count: got %0d required %0d", got_q.size() - g0, exp_q.size()); end
        foreach (exp_q[i]) if (g0 + i < got_q.size()) begin
            checks++; if (got_q[g0 + i] !== exp_q[i]) begin errors++;
                $display("FAIL basic_beat%0d: got %h required %h", i, got_q[g0 + i], exp_q[i]); end
        end
        if (got_q.size() - g0 >= 2) begin
            checks++; if (got_q[g0].keep !== 64'h00000000FFFFFFFF) begin errors++;
                $display("FAIL basic_keep0: got %h required 00000000ffffffff", got_q[g0].keep); end
            checks++; if (got_q[g0 + 1].keep !== 64'h000000000000FFFF) begin errors++;
                $display("FAIL basic_keep1: got %h required 000000000000ffff", got_q[g0 + 1].keep);
            end
            checks++; if (got_cyc[g0] - st != 2) begin errors++;
                $display("FAIL basic_latency: got %0d required 2", got_cyc[g0] - st); end
        end
        checks++; if (pkt_count !== 32'd1) begin errors++;
            $display("FAIL basic_pkt_count: got %0d required 1", pkt_count); end
    endtask

    task automatic test_mty();
        int g0;
        do_reset(1);
        exp_q.delete();
        g0 = got_q.size();
        send_pkt(26, 0, -1, 0);
        for (int k = 0; k < 50 && got_q.size() - g0 < exp_q.size(); k++) tick();
        repeat (4) tick();
        checks++; if (got_q.size() - g0 != 1) begin errors++;
            $display("FAIL mty_count: got %0d required 1", got_q.size() - g0); end
        if (got_q.size() > g0) begin
            checks++; if (got_q[g0] !== exp_q[0]) begin errors++;
                $display("FAIL mty_beat: got %h required %h", got_q[g0], exp_q[0]); end
            checks++; if (got_q[g0].keep !== 64'h0000000003FFFFFF || got_q[g0].last !== 1'b1)
            begin errors++;
                $display("FAIL mty_keep: got %h/%b required 0000000003ffffff/1",
                         got_q[g0].keep, got_q[g0].last); end
        end
    endtask

    task automatic test_error();
        int g0;
        do_reset(1);
        exp_q.delete();
        g0 = got_q.size();
        send_pkt(40, 1, -1, 0);
        send_pkt(100, 0, -1, 0);
        for (int k = 0; k < 50 && got_q.size() - g0 < exp_q.size(); k++) tick();
        repeat (4) tick();
        checks++; if (got_q.size() - g0 != exp_q.size()) begin errors++;
            $display("FAIL err_count: got %0d required %0d", got_q.size() - g0, exp_q.size()); end
        foreach (exp_q[i]) if (g0 + i < got_q.size()) begin
            checks++; if (got_q[g0 + i] !== exp_q[i]) begin errors++;
                $display("FAIL err_beat%0d: got %h required %h", i, got_q[g0 + i], exp_q[i]); end
        end
        if (got_q.size() - g0 >= 2) begin
            checks++; if (got_q[g0 + 1].user !== 1'b1) begin errors++;
                $display("FAIL err_tuser: got %b required 1", got_q[g0 + 1].user); end
        end
        checks++; if (pkt_count !== 32'd2 || drop_count !== 32'd0) begin errors++;
            $display("FAIL err_counts: got %0d/%0d required 2/0", pkt_count, drop_count); end
    endtask

    task automatic test_truncation();
        int g0, o0;
        do_reset(0);
        exp_q.delete();
        g0 = got_q.size();
        o0 = ovf_cnt;
        // Empty FIFO: beats 1..15 fit, beat 16 takes the last slot and closes the packet
        send_pkt(640, 0, DEPTH, 0);
        repeat (4) tick();
        checks++; if (drop_count !== 32'd1) begin errors++;
            $display("FAIL trunc_drop: got %0d required 1", drop_count); end
        checks++; if (ovf_cnt - o0 != 1) begin errors++;
            $display("FAIL trunc_overflow: got %0d pulses required 1", ovf_cnt - o0); end
        checks++; if (pkt_count !== 32'd1) begin errors++;
            $display("FAIL trunc_pkt: got %0d required 1", pkt_count); end
        axis_out_tready = 1'b1;
        for (int k = 0; k < 100 && got_q.size() - g0 < DEPTH; k++) tick();
        send_pkt(64, 0, -1, 0);
        for (int k = 0; k < 100 && got_q.size() - g0 < exp_q.size(); k++) tick();
        repeat (4) tick();
        checks++; if (got_q.size() - g0 != exp_q.size()) begin errors++;
            $display("FAIL trunc_count: got %0d required %0d", got_q.size() - g0, exp_q.size());
        end
        foreach (exp_q[i]) if (g0 + i < got_q.size()) begin
            checks++; if (got_q[g0 + i] !== exp_q[i]) begin errors++;
                $display("FAIL trunc_beat%0d: got %h required %h", i, got_q[g0 + i], exp_q[i]); end
        end
        checks++; if (pkt_count !== 32'd2 || drop_count !== 32'd1) begin errors++;
            $display("FAIL trunc_final: got %0d/%0d required 2/1", pkt_count, drop_count); end
    endtask

    task automatic test_full_start();
        int g0, o0;
        do_reset(0);
        exp_q.delete();
        g0 = got_q.size();
        o0 = ovf_cnt;
        for (int p = 0; p < DEPTH; p++) send_pkt($urandom_range(1, 32), 0, -1, 0);
        // FIFO full: first beat dropped; ready opens so later beats would fit if not discarded
        send_pkt(96, 0, 0, 1);
        repeat (3) tick();
        checks++; if (drop_count !== 32'd1) begin errors++;
            $display("FAIL full_drop: got %0d required 1", drop_count); end
        checks++; if (ovf_cnt - o0 != 1) begin errors++;
            $display("FAIL full_overflow: got %0d pulses required 1", ovf_cnt - o0); end
        for (int k = 0; k < 100 && got_q.size() - g0 < DEPTH; k++) tick();
        send_pkt(70, 0, -1, 0);
        for (int k = 0; k < 100 && got_q.size() - g0 < exp_q.size(); k++) tick();
        repeat (4) tick();
        checks++; if (got_q.size() - g0 != exp_q.size()) begin errors++;
            $display("FAIL full_count: got %0d required %0d", got_q.size() - g0, exp_q.size()); end
        foreach (exp_q[i]) if (g0 + i < got_q.size()) begin
            checks++; if (got_q[g0 + i] !== exp_q[i]) begin errors++;
                $display("FAIL full_beat%0d: got %h required %h", i, got_q[g0 + i], exp_q[i]); end
        end
        checks++; if (pkt_count !== 32'd17 || drop_count !== 32'd1) begin errors++;
            $display("FAIL full_final: got %0d/%0d required 17/1", pkt_count, drop_count); end
    endtask

    task automatic test_reset_mid_packet();
        int    g0;
        beat_t e;
        do_reset(0);
        exp_q.delete();
        g0 = got_q.size();
        send_pkt(20, 0, 0, 0);
        tick();
        tick();
        checks++; if (axis_out_tvalid !== 1'b1) begin errors++;
            $display("FAIL rst_mid_pre: got tvalid %b required 1", axis_out_tvalid); end
        drive_beat(128, 0, 0, e);
        tick();
        drive_beat(128, 0, 1, e);
        #2 reset = 1'b1;
        #1;
        checks++; if (axis_out_tvalid !== 1'b0) begin errors++;
            $display("FAIL rst_mid_tvalid: got %b required 0", axis_out_tvalid); end
        tick();
        reset = 1'b0;
        axis_out_tready = 1'b1;
        drive_beat(128, 0, 2, e);
        tick();
        drive_beat(128, 0, 3, e);
        tick();
        idle_inputs();
        repeat (4) tick();
        checks++; if (got_q.size() != g0) begin errors++;
            $display("FAIL rst_mid_tail: got %0d beats required 0", got_q.size() - g0); end
        send_pkt(72, 0, -1, 0);
        for (int k = 0; k < 50 && got_q.size() - g0 < exp_q.size(); k++) tick();
        repeat (4) tick();
        checks++; if (got_q.size() - g0 != exp_q.size()) begin errors++;
            $display("FAIL rst_mid_count: got %0d required %0d", got_q.size() - g0, exp_q.size());
        end
        foreach (exp_q[i]) if (g0 + i < got_q.size()) begin
            checks++; if (got_q[g0 + i] !== exp_q[i]) begin errors++;
                $display("FAIL rst_mid_beat%0d: got %h required %h", i, got_q[g0 + i], exp_q[i]);
            end
        end
        checks++; if (pkt_count !== 32'd1) begin errors++;
            $display("FAIL rst_mid_pkt: got %0d required 1", pkt_count); end
    endtask

    task automatic test_random();
        int g0, npkt, k, len, nb;
        do_reset(1);
        exp_q.delete();
        g0 = got_q.size();
        npkt = 40;
        rand_rdy = 1'b1;
        for (int p = 0; p < npkt; p++) begin
            len = $urandom_range(1, 128);
            nb  = (len + 31) / 32;
            // Hold off until the packet is sure to fit, so no beat is ever dropped
            for (k = 0; k < 300 && (exp_q.size() - (got_q.size() - g0) + nb > DEPTH - 2); k++)
                tick();
            if (k == 300) begin
                checks++; errors++;
                $display("FAIL rand_stall: got no drain in 300 cycles, required progress");
            end
            send_pkt(len, ($urandom_range(0, 7) == 0), -1, 0);
            repeat ($urandom_range(0, 2)) tick();
        end
        for (k = 0; k < 400 && got_q.size() - g0 < exp_q.size(); k++) tick();
        rand_rdy = 1'b0;
        axis_out_tready = 1'b1;
        for (k = 0; k < 100 && got_q.size() - g0 < exp_q.size(); k++) tick();
        repeat (4) tick();
        checks++; if (got_q.size() - g0 != exp_q.size()) begin errors++;
            $display("FAIL rand_count: got %0d required %0d", got_q.size() - g0, exp_q.size()); end
        foreach (exp_q[i]) if (g0 + i < got_q.size()) begin
            checks++; if (got_q[g0 + i] !== exp_q[i]) begin errors++;
                $display("FAIL rand_beat%0d: got %h required %h", i, got_q[g0 + i], exp_q[i]); end
        end
        checks++; if (pkt_count !== 32'(npkt) || drop_count !== 32'd0) begin errors++;
            $display("FAIL rand_counts: got %0d/%0d required %0d/0", pkt_count, drop_count, npkt);
        end
    endtask

    initial begin
        reset = 1'b1;
        axis_out_tready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            b_data[s]  = '0;
            b_tid[s]   = '0;
            b_user[s]  = '0;
            b_last[s]  = 1'b0;
            b_valid[s] = 1'b0;
        end
        test_reset();
        test_basic();
        test_mty();
        test_error();
        test_truncation();
        test_full_start();
        test_reset_mid_packet();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
